// File: rtl/alu16_seq.sv
// 16-bit register-pair arithmetic sequenced as two byte operations on the shared 8-bit ALU.
// Result and flags are registered and announced by a one-cycle done pulse.
module alu16_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [15:0] opa,
    input  logic [15:0] opb,
    input  logic [3:0]  flags_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic [3:0]  flags_out,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [4:0]  alu_op,
    output logic [3:0]  alu_flags_in,
    input  logic [7:0]  alu_result,
    input  logic [3:0]  alu_flags_out
);

    localparam logic [1:0] OpAdd16 = 2'd0;
    localparam logic [1:0] OpInc16 = 2'd1;
    localparam logic [1:0] OpDec16 = 2'd2;
    localparam logic [1:0] OpAddSp = 2'd3;

    localparam logic [4:0] AluAdd = 5'h00;
    localparam logic [4:0] AluAdc = 5'h01;
    localparam logic [4:0] AluSub = 5'h02;
    localparam logic [4:0] AluSbc = 5'h03;

    localparam int unsigned FlagZ = 3;
    localparam int unsigned FlagH = 1;
    localparam int unsigned FlagC = 0;

    typedef enum logic [1:0] {StIdle, StLo, StHi} state_e;

    state_e      state_q, state_d;
    logic [1:0]  op_q;
    logic [15:0] opa_q, opb_q;
    logic [3:0]  flags_q;
    logic [7:0]  lo_q;
    logic        lo_h_q, lo_c_q;
    logic [15:0] result_q;
    logic [3:0]  flags_out_q;
    logic        done_q;
    logic [3:0]  final_flags;
    logic        accept;

    // Z and N of the ALU are never consumed: Z comes from the CPU, N is implied by the op.
    logic unused_alu_flags;
    assign unused_alu_flags = ^alu_flags_out[3:2];

    assign accept = (state_q == StIdle) && start;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StLo;
            StLo:    state_d = StHi;
            StHi:    state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q        <= 2'd0;
            opa_q       <= 16'h0000;
            opb_q       <= 16'h0000;
            flags_q     <= 4'h0;
            lo_q        <= 8'h00;
            lo_h_q      <= 1'b0;
            lo_c_q      <= 1'b0;
            result_q    <= 16'h0000;
            flags_out_q <= 4'h0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                op_q    <= op;
                opa_q   <= opa;
                opb_q   <= opb;
                flags_q <= flags_in;
            end
            if (state_q == StLo) begin
                lo_q   <= alu_result;
                lo_h_q <= alu_flags_out[FlagH];
                lo_c_q <= alu_flags_out[FlagC];
            end
            if (state_q == StHi) begin
                result_q    <= {alu_result, lo_q};
                flags_out_q <= final_flags;
                done_q      <= 1'b1;
            end
        end
    end

    always_comb begin
        final_flags = flags_q;
        unique case (op_q)
            OpAdd16: final_flags = {flags_q[FlagZ], 1'b0, alu_flags_out[FlagH],
                                    alu_flags_out[FlagC]};
            OpInc16: final_flags = flags_q;
            OpDec16: final_flags = flags_q;
            OpAddSp: final_flags = {2'b00, lo_h_q, lo_c_q};
            default: final_flags = flags_q;
        endcase
    end

    always_comb begin
        alu_a        = 8'h00;
        alu_b        = 8'h00;
        alu_op       = AluAdd;
        alu_flags_in = 4'h0;
        unique case (state_q)
            StLo: begin
                alu_b = opa_q[7:0];
                unique case (op_q)
                    OpInc16: alu_a = 8'h01;
                    OpDec16: begin
                        alu_a  = 8'h01;
                        alu_op = AluSub;
                    end
                    default: alu_a = opb_q[7:0];
                endcase
            end
            StHi: begin
                alu_b        = opa_q[15:8];
                alu_flags_in = {3'b000, lo_c_q};
                alu_op       = AluAdc;
                unique case (op_q)
                    OpAdd16: alu_a = opb_q[15:8];
                    OpInc16: alu_a = 8'h00;
                    OpDec16: begin
                        alu_a  = 8'h00;
                        alu_op = AluSbc;
                    end
                    // Sign-extend e8 into the high byte.
                    default: alu_a = opb_q[7] ? 8'hFF : 8'h00;
                endcase
            end
            default: ;
        endcase
    end

    assign busy      = (state_q == StLo) || (state_q == StHi);
    assign done      = done_q;
    assign result    = result_q;
    assign flags_out = flags_out_q;

endmodule

// File: tb/tb_alu16_seq.sv
// Scoreboard bench for alu16_seq: directed ops push expected results, a monitor checks each done.
// An 8-bit ALU model closes the loop on the alu_* ports.
module tb_alu16_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [15:0] opa, opb;
    logic [3:0]  flags_in;
    logic        busy, done;
    logic [15:0] result;
    logic [3:0]  flags_out;
    logic [7:0]  alu_a, alu_b;
    logic [4:0]  alu_op;
    logic [3:0]  alu_flags_in;
    logic [7:0]  alu_result;
    logic [3:0]  alu_flags_out;

    int checks = 0;
    int errors = 0;
    logic [19:0] exp_q[$];

    always #5 clk = ~clk;

    alu16_seq dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .op            (op),
        .opa           (opa),
        .opb           (opb),
        .flags_in      (flags_in),
        .busy          (busy),
        .done          (done),
        .result        (result),
        .flags_out     (flags_out),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_op        (alu_op),
        .alu_flags_in  (alu_flags_in),
        .alu_result    (alu_result),
        .alu_flags_out (alu_flags_out)
    );

    // ALU model: b+a / b-a with carry-in on ADC/SBC; C is borrow on subtract.
    logic [8:0] full9;
    logic [4:0] half5;
    logic       cin, is_sub;
    always_comb begin
        cin    = (alu_op == 5'h01 || alu_op == 5'h03) ? alu_flags_in[0] : 1'b0;
        is_sub = (alu_op == 5'h02 || alu_op == 5'h03);
        if (is_sub) begin
            full9 = {1'b0, alu_b} - {1'b0, alu_a} - {8'h00, cin};
            half5 = {1'b0, alu_b[3:0]} - {1'b0, alu_a[3:0]} - {4'h0, cin};
        end else begin
            full9 = {1'b0, alu_b} + {1'b0, alu_a} + {8'h00, cin};
            half5 = {1'b0, alu_b[3:0]} + {1'b0, alu_a[3:0]} + {4'h0, cin};
        end
        alu_result    = full9[7:0];
        alu_flags_out = {(full9[7:0] == 8'h00), is_sub, half5[4], full9[8]};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            check("done_busy_overlap", {31'b0, busy}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                logic [19:0] e;
                e = exp_q.pop_front();
                check("result", {16'b0, result}, {16'b0, e[19:4]});
                check("flags_out", {28'b0, flags_out}, {28'b0, e[3:0]});
            end
        end
    end

    task automatic run_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] f, input logic [15:0] er, input logic [3:0] ef);
        @(negedge clk);
        start = 1'b1; op = o; opa = a; opb = b; flags_in = f;
        @(posedge clk);
        exp_q.push_back({er, ef});
        @(negedge clk);
        start = 1'b0;
        check("busy_lo", {31'b0, busy}, 32'd1);
        @(negedge clk);
        check("busy_hi", {31'b0, busy}, 32'd1);
        @(negedge clk);
        check("busy_done_cycle", {31'b0, busy}, 32'd0);
        check("done_pulse", {31'b0, done}, 32'd1);
    endtask

    task automatic set_ops(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                           input logic [3:0] f);
        op = o; opa = a; opb = b; flags_in = f;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 2'd0; opa = 16'h0; opb = 16'h0; flags_in = 4'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_result", {16'b0, result}, 32'd0);
        check("rst_flags", {28'b0, flags_out}, 32'd0);
        check("rst_alu_drive", {11'b0, alu_a, alu_b, alu_op, alu_flags_in}, 32'd0);
        rst_n = 1'b1;

        run_op(2'd0, 16'h0FFF, 16'h0001, 4'b1000, 16'h1000, 4'b1010);
        run_op(2'd0, 16'h8000, 16'h8000, 4'b0000, 16'h0000, 4'b0001);
        run_op(2'd1, 16'hFFFF, 16'h0000, 4'b0101, 16'h0000, 4'b0101);
        run_op(2'd2, 16'h0000, 16'h0000, 4'b0101, 16'hFFFF, 4'b0101);
        run_op(2'd3, 16'hFFF8, 16'hAB08, 4'b1111, 16'h0000, 4'b0011);
        run_op(2'd3, 16'h0000, 16'h00FF, 4'b1111, 16'hFFFF, 4'b0000);

        @(negedge clk);
        check("idle_alu_drive", {11'b0, alu_a, alu_b, alu_op, alu_flags_in}, 32'd0);

        // start held high; only operands present in IDLE/done cycles may be accepted.
        start = 1'b1;
        set_ops(2'd0, 16'h1111, 16'h2222, 4'b0000);
        exp_q.push_back({16'h3333, 4'b0000});
        @(negedge clk); set_ops(2'd1, 16'hFFFF, 16'hFFFF, 4'b1111);
        @(negedge clk); set_ops(2'd2, 16'h5555, 16'h7777, 4'b1010);
        @(negedge clk); set_ops(2'd1, 16'h00FF, 16'h0000, 4'b1111);
        exp_q.push_back({16'h0100, 4'b1111});
        @(negedge clk); set_ops(2'd0, 16'hFFFF, 16'hFFFF, 4'b0000);
        @(negedge clk); set_ops(2'd3, 16'h1234, 16'h0080, 4'b0101);
        @(negedge clk); set_ops(2'd2, 16'h0100, 16'h0000, 4'b0000);
        exp_q.push_back({16'h00FF, 4'b0000});
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);

        // Reset during HI aborts the ADD16 without a done.
        start = 1'b1; set_ops(2'd0, 16'h4321, 16'h1111, 4'b1000);
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        check("abort_in_hi", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_result", {16'b0, result}, 32'd0);
        check("abort_flags", {28'b0, flags_out}, 32'd0);
        @(negedge clk);
        check("abort_no_late_done", {31'b0, done}, 32'd0);

        run_op(2'd1, 16'h1234, 16'h0000, 4'b0010, 16'h1235, 4'b0010);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu16_seq.md
# alu16_seq

Multi-cycle sequencer that performs 16-bit register-pair arithmetic by issuing two back-to-back byte operations to the shared 8-bit ALU. It covers ADD HL,rr, INC rr, DEC rr, and ADD SP,e8 / LD HL,SP+e8. The block sits between the CPU control unit and the ALU. It owns the ALU operand, opcode and flag-input ports only while busy, then returns a registered 16-bit result and final flags with a one-cycle done pulse.

## Interface

Parameters:
- none; flag bit positions are fixed: Z=3, N=2, H=1, C=0.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  reset; one clock, synchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- op  in  2  operation: 0=ADD16, 1=INC16, 2=DEC16, 3=ADDSP.
- opa  in  16  first operand (HL, rr or SP); latched on accepted start.
- opb  in  16  second operand; for ADDSP, opb[7:0] is signed e8 and opb[15:8] is ignored; latched on start.
- flags_in  in  4  CPU flags {Z,N,H,C}; latched on start.
- busy  out  1  high in LO and HI states.
- done  out  1  one-cycle pulse; result and flags_out are valid in this cycle.
- result  out  16  registered result; holds until the next done.
- flags_out  out  4  registered final flags; holds until the next done.
- alu_a, alu_b  out  8  ALU operands (ALU computes b+a or b−a).
- alu_op  out  5  ALU opcode: ADD=5'h00, ADC=5'h01, SUB=5'h02, SBC=5'h03.
- alu_flags_in  out  4  ALU flag input; only the C bit is meaningful.
- alu_result  in  8  ALU combinational result.
- alu_flags_out  in  4  ALU combinational flags; on SUB/SBC, C=1 means borrow.

## Operation

- States: IDLE, LO, HI.
- IDLE → LO on start=1. Operands and flags_in are latched on that edge.
- LO → HI unconditionally. The low byte and ALU flags are captured on the edge that leaves LO.
- HI → IDLE unconditionally. On that edge, result, flags_out and done=1 are registered.
- IDLE drive: alu_a=0, alu_b=0, alu_op=ADD, alu_flags_in=0.
- Low byte (LO state):
  - ADD16 and ADDSP: ADD, b=opa[7:0], a=opb[7:0].
  - INC16: ADD, a=8'h01.
  - DEC16: SUB, a=8'h01.
  - In all cases b=opa[7:0].
- High byte (HI state):
  - alu_flags_in = {3'b0, captured low C}.
  - ADD16: ADC, a=opb[15:8].
  - INC16: ADC, a=8'h00.
  - DEC16: SBC, a=8'h00.
  - ADDSP: ADC, a = opb[7] ? 8'hFF : 8'h00.
  - In all cases b=opa[15:8].
- Final flags:
  - ADD16: Z=latched Z, N=0, H=high-byte H, C=high-byte C.
  - INC16 and DEC16: flags_out = latched flags_in, unchanged.
  - ADDSP: Z=0, N=0, H=low-byte H, C=low-byte C.
- Arithmetic is modulo 2^16. Wrap-around (0xFFFF+1, 0x0000−1) is normal operation, not an error.
- start=1 while busy is ignored: no queueing, and latched operands are unchanged.

## Timing

- Reset (rst_n=0 at an edge) forces:
  - state=IDLE, busy=0, done=0, result=16'h0000, flags_out=4'h0.
  - ALU drive to the IDLE values.
- Reset mid-operation (LO or HI) aborts the operation. No done is produced, and result/flags_out read 0.
- Latency: start accepted at edge k → LO during cycle k..k+1, HI during k+1..k+2, done=1 during k+2..k+3.
- busy=1 exactly in the two cycles following acceptance; done and busy are never high together.
- The done cycle is IDLE, so a new start in the done cycle is accepted. Peak throughput is one operation per 3 cycles.
- The ALU is combinational, so each byte step completes in one cycle and no wait states exist.

## Test plan

- ADD16: opa=0x0FFF, opb=0x0001, flags_in=4'b1000 → after 3 cycles, done=1, result=0x1000, flags_out=4'b1010. busy high for exactly 2 cycles.
- ADD16: opa=0x8000, opb=0x8000, flags_in=0 → result=0x0000, flags_out=4'b0001 (Z not set by the result).
- INC16 0xFFFF with flags_in=4'b0101 → result 0x0000, flags_out=4'b0101. Then DEC16 0x0000 → 0xFFFF, flags unchanged.
- ADDSP:
  - opa=0xFFF8, opb[7:0]=0x08 → result 0x0000, flags_out=4'b0011.
  - opa=0x0000, e8=0xFF → result 0xFFFF, flags_out=4'b0000.
- start held high continuously with changing operands → ops are accepted only in IDLE/done cycles, every 3 cycles. Operand changes during busy do not affect results.
- rst_n=0 during HI of an ADD16 → no done, result=0, flags_out=0, busy=0. An immediately following INC16 0x1234 completes correctly with result 0x1235.
